// File: rtl/order_content_access_ctrl.sv
// order_content_access_ctrl
// Single-port owner of the 4096x200 order-content RAM. Arbitrates order writes
// against order-ID lookups, hides the one-cycle RAM read latency behind a
// short valid pipe, and returns read data in order through a credit-guarded
// response buffer with backpressure.
module order_content_access_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 200,
  parameter int TAG_W        = 8,
  parameter int RSP_DEPTH    = 4,
  parameter int MAX_WR_BURST = 4
) (
  input  logic              axis_aclk,
  input  logic              axis_resetn,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [TAG_W-1:0]  rd_req_tag,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic [TAG_W-1:0]  rd_rsp_tag,
  output logic [ADDR_W-1:0] rd_rsp_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BST_W  = $clog2(MAX_WR_BURST + 1);
  // Stage 0: address presented to RAM; stage 1: RAM data valid on ram_dout.
  localparam int STAGES = 1;

  localparam logic [CNT_W:0]   DEPTH_C = RSP_DEPTH[CNT_W:0];
  localparam logic [BST_W-1:0] BURST_C = MAX_WR_BURST[BST_W-1:0];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } rd_ctx_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
  } rsp_t;

  logic [1:0]               rst_sync;
  logic                     rst_n;
  logic [STAGES:0]          vld_pipe;
  rd_ctx_t [STAGES:0]       ctx_pipe;
  rsp_t                     buf_mem [RSP_DEPTH];
  rsp_t                     head;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         occ;
  logic [CNT_W:0]           credits;
  logic [BST_W-1:0]         burst_cnt;
  logic                     read_priority, read_grantable;
  logic                     wr_gnt, rd_gnt, push, pop;

  // Reset: asserts immediately, releases two clocks after axis_resetn rises.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) rst_sync <= '0;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Credits count every read that will eventually need a buffer slot.
  always_comb begin
    credits = {1'b0, occ}
            + {{CNT_W{1'b0}}, vld_pipe[0]}
            + {{CNT_W{1'b0}}, vld_pipe[1]};
  end

  // Arbitration: writes win unless a starved read has earned priority.
  // Readies are held low while the internal reset is still asserted.
  assign read_grantable = rst_n && (credits < DEPTH_C);
  assign read_priority  = (burst_cnt == BURST_C);
  assign wr_req_ready   = rst_n && (!read_priority || !read_grantable);
  assign rd_req_ready   = read_grantable && (read_priority || !wr_req_valid);
  assign wr_gnt         = wr_req_valid && wr_req_ready;
  assign rd_gnt         = rd_req_valid && rd_req_ready;

  // Write-burst counter: tracks how long a waiting read has been starved.
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n)                         burst_cnt <= '0;
    else if (rd_gnt || !rd_req_valid)   burst_cnt <= '0;
    else if (wr_gnt && !read_priority)  burst_cnt <= burst_cnt + 1'b1;
  end

  // RAM port register: captures the single granted request, idles otherwise.
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
    end else if (wr_gnt) begin
      ram_addr <= wr_req_addr;
      ram_din  <= wr_req_data;
      ram_we   <= 1'b1;
    end else if (rd_gnt) begin
      ram_addr <= rd_req_addr;
      ram_we   <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  // Read pipe: tag/addr ride alongside the RAM access until data returns.
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ctx_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_gnt};
      ctx_pipe[STAGES:1] <= ctx_pipe[STAGES-1:0];
      if (rd_gnt) ctx_pipe[0] <= '{addr: rd_req_addr, tag: rd_req_tag};
    end
  end

  assign push = vld_pipe[STAGES];
  assign pop  = rd_rsp_valid && rd_rsp_ready;

  // Response storage: payload only, validity is tracked by the pointers.
  always_ff @(posedge axis_aclk) begin
    if (push)
      buf_mem[wr_ptr] <= '{data: ram_dout,
                           tag:  ctx_pipe[STAGES].tag,
                           addr: ctx_pipe[STAGES].addr};
  end

  // Circular buffer pointers and occupancy; push and pop may share an edge.
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head         = buf_mem[rd_ptr];
  assign rd_rsp_valid = (occ != '0);
  assign rd_rsp_data  = head.data;
  assign rd_rsp_tag   = head.tag;
  assign rd_rsp_addr  = head.addr;

  // Handshake counters, free-running with natural wrap.
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_gnt) rd_cnt <= rd_cnt + 32'd1;
      if (wr_gnt) wr_cnt <= wr_cnt + 32'd1;
    end
  end

endmodule
